// File: rtl/aes_block_packer.sv
// Packs 32-bit key/plaintext words into 128-bit AES blocks; 1-cycle word->strobe latency when idle.
// Backpressure: word_ready drops while the block FIFO is full or a key is loading; key_word_ready waits for an idle data path.
module aes_block_packer #(
  parameter int DEPTH     = 2,
  parameter int ISSUE_GAP = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     key_word_valid,
  input  logic [31:0]              key_word,
  output logic                     key_word_ready,
  input  logic                     word_valid,
  input  logic [31:0]              word_in,
  output logic                     word_ready,
  output logic [127:0]             cipher_key,
  output logic                     cipherkey_valid_in,
  output logic [127:0]             plain_text,
  output logic                     data_valid_in,
  output logic                     key_loaded,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;

  localparam logic [1:0] KEY_IDLE  = 2'd0;
  localparam logic [1:0] KEY_LOAD  = 2'd1;
  localparam logic [1:0] KEY_ISSUE = 2'd2;

  logic [1:0]    key_state;
  logic [1:0]    key_cnt;
  logic [127:0]  key_buf;
  logic [1:0]    word_cnt;
  logic [127:0]  word_buf;
  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [GW-1:0] gap;

  logic          key_fire;
  logic          word_fire;
  logic          blk_done;
  logic [127:0]  blk;
  logic          issue;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [127:0]  issue_blk;

  assign key_word_ready = (key_state != KEY_ISSUE) && (level == '0) &&
                          (word_cnt == 2'd0) && !data_valid_in;
  assign word_ready     = key_loaded && (level < (AW+1)'(DEPTH)) && (key_state == KEY_IDLE);
  assign key_fire       = key_word_valid && key_word_ready;
  assign word_fire      = word_valid && word_ready;
  assign blk_done       = word_fire && (word_cnt == 2'd3);
  assign blk            = {word_buf[127:32], word_in};

  // An empty FIFO lets a just-completed block bypass straight to the output register.
  assign issue     = !flush && (gap == '0) && ((level != '0) || blk_done);
  assign fifo_wr   = !flush && blk_done && !((level == '0) && issue);
  assign fifo_rd   = issue && (level != '0);
  assign issue_blk = (level != '0) ? mem[rd_ptr] : blk;
  assign fifo_level = level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_state          <= KEY_IDLE;
      key_cnt            <= 2'd0;
      key_buf            <= '0;
      cipher_key         <= '0;
      cipherkey_valid_in <= 1'b0;
      key_loaded         <= 1'b0;
    end else begin
      cipherkey_valid_in <= 1'b0;
      case (key_state)
        KEY_IDLE, KEY_LOAD: begin
          if (key_fire) begin
            key_buf[127 - 32*int'(key_cnt) -: 32] <= key_word;
            key_cnt <= key_cnt + 2'd1;
            if (key_cnt == 2'd3) begin
              cipher_key         <= {key_buf[127:32], key_word};
              cipherkey_valid_in <= 1'b1;
              key_loaded         <= 1'b1;
              key_state          <= KEY_ISSUE;
            end else begin
              key_state <= KEY_LOAD;
            end
          end
        end
        KEY_ISSUE: key_state <= KEY_IDLE;
        default:   key_state <= KEY_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt      <= 2'd0;
      word_buf      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      gap           <= '0;
      plain_text    <= '0;
      data_valid_in <= 1'b0;
    end else begin
      data_valid_in <= issue;
      if (issue) plain_text <= issue_blk;

      if (word_fire) word_buf[127 - 32*int'(word_cnt) -: 32] <= word_in;

      if (flush) begin
        word_cnt <= 2'd0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        gap      <= '0;
      end else begin
        if (word_fire) word_cnt <= word_cnt + 2'd1;
        if (fifo_wr)   wr_ptr   <= wr_ptr + AW'(1);
        if (fifo_rd)   rd_ptr   <= rd_ptr + AW'(1);
        case ({fifo_wr, fifo_rd})
          2'b10:   level <= level + (AW+1)'(1);
          2'b01:   level <= level - (AW+1)'(1);
          default: level <= level;
        endcase
        if (issue)           gap <= GW'(ISSUE_GAP);
        else if (gap != '0)  gap <= gap - GW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= blk;
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed bench for aes_block_packer (DEPTH=2, ISSUE_GAP=7 so the block FIFO can fill).
module tb_aes_block_packer;
  localparam int DEPTH = 2;
  localparam int GAP   = 7;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         key_word_valid = 1'b0;
  logic [31:0]  key_word = '0;
  logic         key_word_ready;
  logic         word_valid = 1'b0;
  logic [31:0]  word_in = '0;
  logic         word_ready;
  logic [127:0] cipher_key;
  logic         cipherkey_valid_in;
  logic [127:0] plain_text;
  logic         data_valid_in;
  logic         key_loaded;
  logic [1:0]   fifo_level;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ck_pulses = 0;
  logic [127:0] dv_q[$];
  int dv_t[$];

  localparam logic [127:0] KEY_EXP  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BLK_EXP  = 128'h00112233445566778899aabbccddeeff;

  aes_block_packer #(.DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .key_word_valid(key_word_valid), .key_word(key_word), .key_word_ready(key_word_ready),
    .word_valid(word_valid), .word_in(word_in), .word_ready(word_ready),
    .cipher_key(cipher_key), .cipherkey_valid_in(cipherkey_valid_in),
    .plain_text(plain_text), .data_valid_in(data_valid_in),
    .key_loaded(key_loaded), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_valid_in === 1'b1) begin
      dv_q.push_back(plain_text);
      dv_t.push_back(cyc);
    end
    if (cipherkey_valid_in === 1'b1) ck_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    word_valid = 1'b1;
    word_in    = w;
    while (word_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (n >= 200) begin n_fail++; $display("FAIL send_word_timeout word_ready=%b required 1", word_ready); end
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic send_key(input logic [31:0] w);
    int n = 0;
    key_word_valid = 1'b1;
    key_word       = w;
    while (key_word_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (n >= 200) begin n_fail++; $display("FAIL send_key_timeout key_word_ready=%b required 1", key_word_ready); end
    @(negedge clk);
    key_word_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({cipher_key, plain_text, cipherkey_valid_in, data_valid_in, key_loaded, fifo_level, word_ready} !== '0) begin
      n_fail++; $display("FAIL reset_outputs ck=%h pt=%h ckv=%b dv=%b kl=%b lvl=%0d wr=%b required all 0",
        cipher_key, plain_text, cipherkey_valid_in, data_valid_in, key_loaded, fifo_level, word_ready);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (key_word_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_ready got %b required 1", key_word_ready); end
  endtask

  task automatic test_no_key;
    word_valid = 1'b1;
    word_in    = 32'hdeadbeef;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (word_ready !== 1'b0) begin n_fail++; $display("FAIL nokey_word_ready got %b required 0", word_ready); end
    end
    word_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dv_q.size() != 0 || fifo_level !== 2'd0) begin
      n_fail++; $display("FAIL nokey_issue pulses=%0d lvl=%0d required 0 0", dv_q.size(), fifo_level);
    end
  endtask

  task automatic test_key_load;
    int ck0 = ck_pulses;
    send_key(32'h00010203);
    send_key(32'h04050607);
    send_key(32'h08090a0b);
    send_key(32'h0c0d0e0f);
    n_checks++;
    if (cipherkey_valid_in !== 1'b1 || cipher_key !== KEY_EXP || key_loaded !== 1'b1) begin
      n_fail++; $display("FAIL key_issue ckv=%b ck=%h kl=%b required 1 %h 1", cipherkey_valid_in, cipher_key, key_loaded, KEY_EXP);
    end
    n_checks++;
    if (word_ready !== 1'b0) begin n_fail++; $display("FAIL key_issue_word_ready got %b required 0", word_ready); end
    @(negedge clk);
    n_checks++;
    if (cipherkey_valid_in !== 1'b0 || cipher_key !== KEY_EXP || key_loaded !== 1'b1) begin
      n_fail++; $display("FAIL key_hold ckv=%b ck=%h kl=%b required 0 %h 1", cipherkey_valid_in, cipher_key, key_loaded, KEY_EXP);
    end
    @(negedge clk);
    n_checks++;
    if (ck_pulses != ck0 + 1) begin n_fail++; $display("FAIL key_pulse_count got %0d required %0d", ck_pulses - ck0, 1); end
  endtask

  task automatic test_data_block;
    send_word(32'h00112233);
    send_word(32'h44556677);
    send_word(32'h8899aabb);
    send_word(32'hccddeeff);
    n_checks++;
    if (data_valid_in !== 1'b1 || plain_text !== BLK_EXP) begin
      n_fail++; $display("FAIL data_latency dv=%b pt=%h required 1 %h", data_valid_in, plain_text, BLK_EXP);
    end
    @(negedge clk);
    n_checks++;
    if (data_valid_in !== 1'b0 || plain_text !== BLK_EXP || fifo_level !== 2'd0) begin
      n_fail++; $display("FAIL data_hold dv=%b pt=%h lvl=%0d required 0 %h 0", data_valid_in, plain_text, fifo_level, BLK_EXP);
    end
    repeat (GAP + 2) @(negedge clk);
  endtask

  task automatic test_key_blocked;
    send_word(32'h11111111);
    send_word(32'h22222222);
    n_checks++;
    if (key_word_ready !== 1'b0) begin n_fail++; $display("FAIL keyblk_partial got %b required 0", key_word_ready); end
    send_word(32'h33333333);
    send_word(32'h44444444);
    n_checks++;
    if (data_valid_in !== 1'b1 || key_word_ready !== 1'b0 || plain_text !== 128'h11111111222222223333333344444444) begin
      n_fail++; $display("FAIL keyblk_issue dv=%b kwr=%b pt=%h required 1 0 11111111222222223333333344444444",
        data_valid_in, key_word_ready, plain_text);
    end
    @(negedge clk);
    n_checks++;
    if (key_word_ready !== 1'b1) begin n_fail++; $display("FAIL keyblk_drained got %b required 1", key_word_ready); end
    repeat (GAP + 2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [127:0] exp_blk [5];
    int max_lvl = 0;
    int stalls = 0;
    int n = 0;
    dv_q.delete();
    dv_t.delete();
    for (int b = 0; b < 5; b++)
      exp_blk[b] = {32'hb0000000 + 32'(b*16), 32'hb0000001 + 32'(b*16),
                    32'hb0000002 + 32'(b*16), 32'hb0000003 + 32'(b*16)};
    fork
      begin
        for (int b = 0; b < 5; b++)
          for (int j = 0; j < 4; j++) send_word(32'hb0000000 + 32'(b*16 + j));
      end
      begin
        repeat (40) begin
          @(negedge clk);
          n_checks++;
          if (word_ready !== (fifo_level < 2'd2)) begin
            n_fail++; $display("FAIL b2b_ready wr=%b lvl=%0d required %b", word_ready, fifo_level, fifo_level < 2'd2);
          end
          if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
          if (word_valid && !word_ready) stalls++;
        end
      end
    join
    while (dv_q.size() < 5 && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (dv_q.size() != 5) begin n_fail++; $display("FAIL b2b_count got %0d required 5", dv_q.size()); end
    n_checks++;
    if (max_lvl != DEPTH || stalls == 0) begin
      n_fail++; $display("FAIL b2b_full max_lvl=%0d stalls=%0d required %0d >0", max_lvl, stalls, DEPTH);
    end
    for (int b = 0; b < 5 && b < dv_q.size(); b++) begin
      n_checks++;
      if (dv_q[b] !== exp_blk[b]) begin n_fail++; $display("FAIL b2b_order[%0d] got %h required %h", b, dv_q[b], exp_blk[b]); end
      if (b > 0) begin
        n_checks++;
        if (dv_t[b] - dv_t[b-1] != GAP + 1) begin
          n_fail++; $display("FAIL b2b_spacing[%0d] got %0d required %0d", b, dv_t[b] - dv_t[b-1], GAP + 1);
        end
      end
    end
    repeat (GAP + 2) @(negedge clk);
  endtask

  task automatic test_flush;
    int ck0 = ck_pulses;
    send_word(32'haaaa0000);
    send_word(32'haaaa0001);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    dv_q.delete();
    send_word(32'h55550000);
    send_word(32'h55550001);
    send_word(32'h55550002);
    send_word(32'h55550003);
    n_checks++;
    if (data_valid_in !== 1'b1 || plain_text !== 128'h55550000555500015555000255550003) begin
      n_fail++; $display("FAIL flush_new_block dv=%b pt=%h required 1 55550000555500015555000255550003", data_valid_in, plain_text);
    end
    repeat (GAP + 2) @(negedge clk);
    // Flush coinciding with the completing word must discard that block.
    send_word(32'h77770000);
    send_word(32'h77770001);
    send_word(32'h77770002);
    flush = 1'b1;
    send_word(32'h77770003);
    flush = 1'b0;
    dv_q.delete();
    repeat (10) @(negedge clk);
    n_checks++;
    if (dv_q.size() != 0 || fifo_level !== 2'd0) begin
      n_fail++; $display("FAIL flush_wins pulses=%0d lvl=%0d required 0 0", dv_q.size(), fifo_level);
    end
    n_checks++;
    if (cipher_key !== KEY_EXP || key_loaded !== 1'b1 || ck_pulses != ck0) begin
      n_fail++; $display("FAIL flush_key ck=%h kl=%b pulses=%0d required %h 1 0", cipher_key, key_loaded, ck_pulses - ck0, KEY_EXP);
    end
  endtask

  task automatic test_reset_midstream;
    send_word(32'h99990000);
    send_word(32'h99990001);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({cipher_key, plain_text, cipherkey_valid_in, data_valid_in, key_loaded, fifo_level, word_ready} !== '0) begin
      n_fail++; $display("FAIL rst_mid_block ck=%h pt=%h kl=%b lvl=%0d wr=%b required all 0",
        cipher_key, plain_text, key_loaded, fifo_level, word_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    send_key(32'hffff0000);
    send_key(32'hffff0001);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (cipher_key !== '0 || key_loaded !== 1'b0 || cipherkey_valid_in !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_key ck=%h kl=%b ckv=%b required 0 0 0", cipher_key, key_loaded, cipherkey_valid_in);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_key_load();
    test_data_block();
  endtask

  initial begin
    test_reset();
    test_no_key();
    test_key_load();
    test_data_block();
    test_key_blocked();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
